// File: rtl/ca_ps_sequencer_if.sv
// CA power-supply sequencer signal bundle.
// master drives operator/interlock inputs, slave is the sequencer.
interface ca_ps_sequencer_if;
    logic       start_req;
    logic       stop_req;
    logic       fault_ack;
    logic       perm_n;
    logic       not_ca_ok;
    logic       i_high_n;
    logic       u_low_n;
    logic       ca_ps_act;
    logic [2:0] state;
    logic       fault_latched;
    logic [2:0] fault_code;
    logic [1:0] retry_cnt;

    modport master (
        output start_req, stop_req, fault_ack,
        output perm_n, not_ca_ok, i_high_n, u_low_n,
        input  ca_ps_act, state, fault_latched,
        input  fault_code, retry_cnt
    );

    modport slave (
        input  start_req, stop_req, fault_ack,
        input  perm_n, not_ca_ok, i_high_n, u_low_n,
        output ca_ps_act, state, fault_latched,
        output fault_code, retry_cnt
    );
endinterface

// File: rtl/ca_ps_sequencer.sv
// CA power-supply on/off sequencer with fault latching and lockout.
// Define CA_AUTO_RETRY_EN to enable timed back-off and automatic re-arm.
module ca_ps_sequencer #(
    parameter int OK_TIMEOUT     = 4352,
    parameter int BACKOFF_CYCLES = 512,
    parameter int MAX_RETRY      = 3
) (
    input  logic                 clk,
    input  logic                 reset,
    ca_ps_sequencer_if.slave     bus
);

`ifdef CA_AUTO_RETRY_EN
    localparam bit AUTO_RETRY = 1'b1;
`else
    localparam bit AUTO_RETRY = 1'b0;
`endif

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_ARM     = 3'd1,
        S_WAIT_OK = 3'd2,
        S_RUN     = 3'd3,
        S_FAULT   = 3'd4,
        S_BACKOFF = 3'd5,
        S_LOCKOUT = 3'd6,
        S_BAD     = 3'd7
    } state_t;

    localparam logic [2:0] FC_PERM    = 3'd1;
    localparam logic [2:0] FC_OC      = 3'd2;
    localparam logic [2:0] FC_UV      = 3'd3;
    localparam logic [2:0] FC_OK_LOST = 3'd4;
    localparam logic [2:0] FC_TIMEOUT = 3'd5;

    localparam int TW = $clog2(OK_TIMEOUT + 1);
    localparam int BW = $clog2(BACKOFF_CYCLES + 1);
    localparam logic [TW-1:0] T_LAST = TW'(OK_TIMEOUT - 1);
    localparam logic [BW-1:0] B_LAST = BW'(BACKOFF_CYCLES - 1);

    state_t        st;
    state_t        st_nxt;
    logic          act_q;
    logic [TW-1:0] timer;
    logic [BW-1:0] bo_cnt;
    logic          latched_q;
    logic [2:0]    code_q;
    logic [1:0]    retry_q;

    logic          fault_hit;
    logic [2:0]    fault_cause;
    logic          stop_go;
    logic          clr_all;
    logic          bo_done;
    logic          retry_ok;
    logic [1:0]    retry_inc;

    assign bo_done   = (bo_cnt == B_LAST);
    assign retry_ok  = (int'({30'd0, retry_q}) <= MAX_RETRY);
    assign retry_inc = (retry_q == 2'd3) ? 2'd3 : retry_q + 2'd1;

    // Fault detection per active state, highest priority cause first.
    always_comb begin
        fault_hit   = 1'b0;
        fault_cause = 3'd0;
        case (st)
            S_ARM: begin
                if (bus.perm_n) begin
                    fault_hit   = 1'b1;
                    fault_cause = FC_PERM;
                end
            end
            S_WAIT_OK: begin
                if (bus.perm_n) begin
                    fault_hit   = 1'b1;
                    fault_cause = FC_PERM;
                end else if (bus.not_ca_ok && timer == T_LAST) begin
                    fault_hit   = 1'b1;
                    fault_cause = FC_TIMEOUT;
                end
            end
            S_RUN: begin
                if (bus.perm_n) begin
                    fault_hit   = 1'b1;
                    fault_cause = FC_PERM;
                end else if (!bus.i_high_n) begin
                    fault_hit   = 1'b1;
                    fault_cause = FC_OC;
                end else if (!bus.u_low_n) begin
                    fault_hit   = 1'b1;
                    fault_cause = FC_UV;
                end else if (bus.not_ca_ok) begin
                    fault_hit   = 1'b1;
                    fault_cause = FC_OK_LOST;
                end
            end
            default: ;
        endcase
    end

    // Next-state selection; faults outrank stop, stop outranks progress.
    always_comb begin
        st_nxt  = st;
        stop_go = 1'b0;
        clr_all = 1'b0;
        case (st)
            S_IDLE: begin
                if (bus.start_req && !bus.perm_n) st_nxt = S_ARM;
            end
            S_ARM: begin
                if (fault_hit) begin
                    st_nxt = S_FAULT;
                end else if (bus.stop_req) begin
                    st_nxt  = S_IDLE;
                    stop_go = 1'b1;
                end else begin
                    st_nxt = S_WAIT_OK;
                end
            end
            S_WAIT_OK: begin
                if (fault_hit) begin
                    st_nxt = S_FAULT;
                end else if (bus.stop_req) begin
                    st_nxt  = S_IDLE;
                    stop_go = 1'b1;
                end else if (!bus.not_ca_ok) begin
                    st_nxt = S_RUN;
                end
            end
            S_RUN: begin
                if (fault_hit) begin
                    st_nxt = S_FAULT;
                end else if (bus.stop_req) begin
                    st_nxt  = S_IDLE;
                    stop_go = 1'b1;
                end
            end
            S_FAULT: begin
                st_nxt = (AUTO_RETRY && retry_ok) ? S_BACKOFF : S_LOCKOUT;
            end
            S_BACKOFF: begin
                if (bus.fault_ack) begin
                    st_nxt  = S_IDLE;
                    clr_all = 1'b1;
                end else if (bus.stop_req) begin
                    st_nxt  = S_IDLE;
                    stop_go = 1'b1;
                end else if (bo_done && !bus.perm_n) begin
                    st_nxt = S_ARM;
                end
            end
            S_LOCKOUT: begin
                if (bus.fault_ack && !bus.perm_n) begin
                    st_nxt  = S_IDLE;
                    clr_all = 1'b1;
                end
            end
            default: st_nxt = S_LOCKOUT;
        endcase
    end

    // State register and activate command, updated on the same edge.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            st    <= S_IDLE;
            act_q <= 1'b0;
        end else begin
            st    <= st_nxt;
            act_q <= (st_nxt == S_ARM) || (st_nxt == S_WAIT_OK) ||
                     (st_nxt == S_RUN);
        end
    end

    // WAIT_OK timer, cleared in ARM and held once at its last value.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            timer <= '0;
        end else if (st == S_ARM) begin
            timer <= '0;
        end else if (st == S_WAIT_OK && timer != T_LAST) begin
            timer <= timer + TW'(1);
        end
    end

    // Back-off counter, runs only while in BACKOFF.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            bo_cnt <= '0;
        end else if (st != S_BACKOFF) begin
            bo_cnt <= '0;
        end else if (!bo_done) begin
            bo_cnt <= bo_cnt + BW'(1);
        end
    end

    // Fault record: first cause sticks until acknowledged.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            latched_q <= 1'b0;
            code_q    <= 3'd0;
            retry_q   <= 2'd0;
        end else if (fault_hit) begin
            latched_q <= 1'b1;
            retry_q   <= retry_inc;
            if (!latched_q) code_q <= fault_cause;
        end else if (clr_all) begin
            latched_q <= 1'b0;
            code_q    <= 3'd0;
            retry_q   <= 2'd0;
        end else if (stop_go) begin
            retry_q   <= 2'd0;
        end
    end

    assign bus.state         = st;
    assign bus.ca_ps_act     = act_q;
    assign bus.fault_latched = latched_q;
    assign bus.fault_code    = code_q;
    assign bus.retry_cnt     = retry_q;

endmodule

// File: tb/tb_ca_ps_sequencer.sv
// Directed self-checking bench for ca_ps_sequencer.
// Covers both builds; retry scenarios follow CA_AUTO_RETRY_EN.
module tb_ca_ps_sequencer;
    logic clk = 1'b0;
    logic reset;
    int   n_tests = 0;
    int   n_fail  = 0;

    ca_ps_sequencer_if bus();

    ca_ps_sequencer #(
        .OK_TIMEOUT     (16),
        .BACKOFF_CYCLES (8),
        .MAX_RETRY      (2)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic idle_inputs();
        bus.start_req = 1'b0;
        bus.stop_req  = 1'b0;
        bus.fault_ack = 1'b0;
        bus.perm_n    = 1'b0;
        bus.not_ca_ok = 1'b1;
        bus.i_high_n  = 1'b1;
        bus.u_low_n   = 1'b1;
    endtask

    task automatic wait_state(input logic [2:0] want, input int bound,
                              input string tag);
        int k = 0;
        while (bus.state !== want && k < bound) begin
            tick();
            k++;
        end
        n_tests++;
        if (bus.state !== want) begin
            n_fail++;
            $display("FAIL %s state=%0d want %0d", tag, bus.state, want);
        end
    endtask

    task automatic go_run();
        bus.start_req = 1'b1;
        bus.not_ca_ok = 1'b0;
        tick();
        bus.start_req = 1'b0;
        wait_state(3'd3, 10, "go_run");
    endtask

    task automatic test_reset();
        idle_inputs();
        reset = 1'b1;
        tick();
        tick();
        n_tests++;
        if (bus.state !== 3'd0) begin
            n_fail++; $display("FAIL rst_state got %0d want 0", bus.state);
        end
        n_tests++;
        if (bus.ca_ps_act !== 1'b0) begin
            n_fail++; $display("FAIL rst_act got %b want 0", bus.ca_ps_act);
        end
        n_tests++;
        if (bus.fault_latched !== 1'b0) begin
            n_fail++; $display("FAIL rst_latch got %b want 0", bus.fault_latched);
        end
        n_tests++;
        if (bus.fault_code !== 3'd0) begin
            n_fail++; $display("FAIL rst_code got %0d want 0", bus.fault_code);
        end
        n_tests++;
        if (bus.retry_cnt !== 2'd0) begin
            n_fail++; $display("FAIL rst_retry got %0d want 0", bus.retry_cnt);
        end
        reset = 1'b0;
        tick();
        n_tests++;
        if (bus.state !== 3'd0) begin
            n_fail++; $display("FAIL post_rst got %0d want 0", bus.state);
        end
    endtask

    task automatic test_nominal();
        logic bad = 1'b0;
        idle_inputs();
        bus.perm_n    = 1'b1;
        bus.start_req = 1'b1;
        tick();
        n_tests++;
        if (bus.state !== 3'd0) begin
            n_fail++; $display("FAIL start_noperm got %0d want 0", bus.state);
        end
        bus.perm_n = 1'b0;
        tick();
        n_tests++;
        if (bus.state !== 3'd1 || bus.ca_ps_act !== 1'b1) begin
            n_fail++;
            $display("FAIL nom_arm state=%0d act=%b want 1/1",
                     bus.state, bus.ca_ps_act);
        end
        bus.start_req = 1'b0;
        for (int i = 0; i < 5; i++) begin
            tick();
            if (bus.state !== 3'd2 || bus.ca_ps_act !== 1'b1) bad = 1'b1;
        end
        n_tests++;
        if (bad !== 1'b0) begin
            n_fail++; $display("FAIL nom_wait state=%0d want 2", bus.state);
        end
        bus.not_ca_ok = 1'b0;
        tick();
        n_tests++;
        if (bus.state !== 3'd3 || bus.ca_ps_act !== 1'b1) begin
            n_fail++;
            $display("FAIL nom_run state=%0d act=%b want 3/1",
                     bus.state, bus.ca_ps_act);
        end
        bus.fault_ack = 1'b1;
        tick();
        bus.fault_ack = 1'b0;
        n_tests++;
        if (bus.state !== 3'd3) begin
            n_fail++; $display("FAIL ack_in_run got %0d want 3", bus.state);
        end
        bus.stop_req = 1'b1;
        tick();
        bus.stop_req = 1'b0;
        n_tests++;
        if (bus.state !== 3'd0 || bus.ca_ps_act !== 1'b0) begin
            n_fail++;
            $display("FAIL nom_stop state=%0d act=%b want 0/0",
                     bus.state, bus.ca_ps_act);
        end
        n_tests++;
        if (bus.fault_latched !== 1'b0) begin
            n_fail++; $display("FAIL nom_latch got %b want 0", bus.fault_latched);
        end
    endtask

    task automatic test_stop_early();
        idle_inputs();
        bus.start_req = 1'b1;
        tick();
        bus.start_req = 1'b0;
        bus.stop_req  = 1'b1;
        tick();
        bus.stop_req  = 1'b0;
        n_tests++;
        if (bus.state !== 3'd0 || bus.ca_ps_act !== 1'b0) begin
            n_fail++;
            $display("FAIL stop_arm state=%0d act=%b want 0/0",
                     bus.state, bus.ca_ps_act);
        end
    endtask

    task automatic test_timeout();
        logic bad = 1'b0;
        idle_inputs();
        bus.start_req = 1'b1;
        tick();
        bus.start_req = 1'b0;
        for (int i = 0; i < 16; i++) begin
            tick();
            if (bus.state !== 3'd2) bad = 1'b1;
        end
        n_tests++;
        if (bad !== 1'b0) begin
            n_fail++; $display("FAIL to_wait early exit state=%0d", bus.state);
        end
        tick();
        n_tests++;
        if (bus.state !== 3'd4 || bus.ca_ps_act !== 1'b0) begin
            n_fail++;
            $display("FAIL to_fault state=%0d act=%b want 4/0",
                     bus.state, bus.ca_ps_act);
        end
        n_tests++;
        if (bus.fault_code !== 3'd5 || bus.fault_latched !== 1'b1) begin
            n_fail++;
            $display("FAIL to_code code=%0d latch=%b want 5/1",
                     bus.fault_code, bus.fault_latched);
        end
        n_tests++;
        if (bus.retry_cnt !== 2'd1) begin
            n_fail++; $display("FAIL to_retry got %0d want 1", bus.retry_cnt);
        end
        tick();
        n_tests++;
`ifdef CA_AUTO_RETRY_EN
        if (bus.state !== 3'd5) begin
            n_fail++; $display("FAIL to_next got %0d want 5", bus.state);
        end
`else
        if (bus.state !== 3'd6) begin
            n_fail++; $display("FAIL to_next got %0d want 6", bus.state);
        end
`endif
        bus.fault_ack = 1'b1;
        tick();
        bus.fault_ack = 1'b0;
        n_tests++;
        if (bus.state !== 3'd0 || bus.fault_latched !== 1'b0 ||
            bus.fault_code !== 3'd0 || bus.retry_cnt !== 2'd0) begin
            n_fail++;
            $display("FAIL to_ack state=%0d latch=%b code=%0d retry=%0d",
                     bus.state, bus.fault_latched, bus.fault_code,
                     bus.retry_cnt);
        end
    endtask

    task automatic test_codes();
        logic [2:0] vin [3];
        logic [2:0] want [3];
        vin[0] = 3'b001; want[0] = 3'd2;
        vin[1] = 3'b101; want[1] = 3'd3;
        vin[2] = 3'b111; want[2] = 3'd4;
        for (int i = 0; i < 3; i++) begin
            idle_inputs();
            go_run();
            bus.i_high_n  = vin[i][2];
            bus.u_low_n   = vin[i][1];
            bus.not_ca_ok = vin[i][0];
            tick();
            n_tests++;
            if (bus.state !== 3'd4 || bus.fault_code !== want[i]) begin
                n_fail++;
                $display("FAIL code_%0d state=%0d code=%0d want 4/%0d",
                         i, bus.state, bus.fault_code, want[i]);
            end
            idle_inputs();
            tick();
            bus.fault_ack = 1'b1;
            tick();
            bus.fault_ack = 1'b0;
            n_tests++;
            if (bus.state !== 3'd0 || bus.fault_code !== 3'd0) begin
                n_fail++;
                $display("FAIL code_clr_%0d state=%0d code=%0d",
                         i, bus.state, bus.fault_code);
            end
        end
    endtask

    task automatic test_priority();
        idle_inputs();
        go_run();
        bus.perm_n   = 1'b1;
        bus.i_high_n = 1'b0;
        bus.stop_req = 1'b1;
        tick();
        bus.perm_n   = 1'b0;
        bus.i_high_n = 1'b1;
        bus.stop_req = 1'b0;
        n_tests++;
        if (bus.state !== 3'd4 || bus.fault_code !== 3'd1 ||
            bus.ca_ps_act !== 1'b0) begin
            n_fail++;
            $display("FAIL prio state=%0d code=%0d act=%b want 4/1/0",
                     bus.state, bus.fault_code, bus.ca_ps_act);
        end
        tick();
`ifdef CA_AUTO_RETRY_EN
        n_tests++;
        if (bus.state !== 3'd5) begin
            n_fail++; $display("FAIL prio_bo got %0d want 5", bus.state);
        end
        wait_state(3'd3, 30, "prio_rerun");
        bus.i_high_n = 1'b0;
        tick();
        bus.i_high_n = 1'b1;
        n_tests++;
        if (bus.state !== 3'd4 || bus.fault_code !== 3'd1 ||
            bus.retry_cnt !== 2'd2) begin
            n_fail++;
            $display("FAIL prio_first state=%0d code=%0d retry=%0d",
                     bus.state, bus.fault_code, bus.retry_cnt);
        end
        tick();
`else
        n_tests++;
        if (bus.state !== 3'd6 || bus.fault_code !== 3'd1) begin
            n_fail++;
            $display("FAIL prio_lock state=%0d code=%0d want 6/1",
                     bus.state, bus.fault_code);
        end
`endif
        bus.fault_ack = 1'b1;
        tick();
        bus.fault_ack = 1'b0;
        n_tests++;
        if (bus.state !== 3'd0 || bus.fault_code !== 3'd0) begin
            n_fail++;
            $display("FAIL prio_ack state=%0d code=%0d",
                     bus.state, bus.fault_code);
        end
    endtask

`ifdef CA_AUTO_RETRY_EN
    task automatic test_retry();
        logic bad = 1'b0;
        idle_inputs();
        go_run();
        for (int r = 1; r <= 3; r++) begin
            bus.i_high_n = 1'b0;
            tick();
            bus.i_high_n = 1'b1;
            n_tests++;
            if (bus.state !== 3'd4 || bus.retry_cnt !== 2'(r)) begin
                n_fail++;
                $display("FAIL retry_%0d state=%0d cnt=%0d",
                         r, bus.state, bus.retry_cnt);
            end
            if (r < 3) begin
                tick();
                n_tests++;
                if (bus.state !== 3'd5) begin
                    n_fail++; $display("FAIL retry_bo got %0d", bus.state);
                end
                if (r == 1) begin
                    for (int i = 0; i < 7; i++) begin
                        tick();
                        if (bus.state !== 3'd5) bad = 1'b1;
                    end
                    tick();
                    n_tests++;
                    if (bad !== 1'b0 || bus.state !== 3'd1 ||
                        bus.fault_latched !== 1'b1) begin
                        n_fail++;
                        $display("FAIL bo_len state=%0d latch=%b",
                                 bus.state, bus.fault_latched);
                    end
                end
                wait_state(3'd3, 30, "retry_rearm");
            end
        end
        tick();
        n_tests++;
        if (bus.state !== 3'd6 || bus.retry_cnt !== 2'd3) begin
            n_fail++;
            $display("FAIL retry_lock state=%0d cnt=%0d want 6/3",
                     bus.state, bus.retry_cnt);
        end
        bus.fault_ack = 1'b1;
        tick();
        bus.fault_ack = 1'b0;
        n_tests++;
        if (bus.state !== 3'd0 || bus.retry_cnt !== 2'd0) begin
            n_fail++;
            $display("FAIL retry_ack state=%0d cnt=%0d",
                     bus.state, bus.retry_cnt);
        end
    endtask
`else
    task automatic test_no_retry();
        idle_inputs();
        go_run();
        bus.u_low_n = 1'b0;
        tick();
        bus.u_low_n = 1'b1;
        n_tests++;
        if (bus.state !== 3'd4 || bus.fault_code !== 3'd3) begin
            n_fail++;
            $display("FAIL nr_fault state=%0d code=%0d want 4/3",
                     bus.state, bus.fault_code);
        end
        tick();
        n_tests++;
        if (bus.state !== 3'd6 || bus.ca_ps_act !== 1'b0) begin
            n_fail++;
            $display("FAIL nr_lock state=%0d act=%b want 6/0",
                     bus.state, bus.ca_ps_act);
        end
        bus.perm_n    = 1'b1;
        bus.fault_ack = 1'b1;
        tick();
        tick();
        n_tests++;
        if (bus.state !== 3'd6) begin
            n_fail++; $display("FAIL nr_ack_noperm got %0d want 6", bus.state);
        end
        bus.perm_n = 1'b0;
        tick();
        bus.fault_ack = 1'b0;
        n_tests++;
        if (bus.state !== 3'd0 || bus.retry_cnt !== 2'd0 ||
            bus.fault_latched !== 1'b0) begin
            n_fail++;
            $display("FAIL nr_ack state=%0d cnt=%0d latch=%b",
                     bus.state, bus.retry_cnt, bus.fault_latched);
        end
    endtask
`endif

    task automatic test_async_reset();
        idle_inputs();
        bus.start_req = 1'b1;
        tick();
        bus.start_req = 1'b0;
        tick();
        #2 reset = 1'b1;
        #1;
        n_tests++;
        if (bus.state !== 3'd0 || bus.ca_ps_act !== 1'b0 ||
            bus.fault_latched !== 1'b0) begin
            n_fail++;
            $display("FAIL arst_wait state=%0d act=%b latch=%b",
                     bus.state, bus.ca_ps_act, bus.fault_latched);
        end
        tick();
        reset = 1'b0;
        go_run();
        #2 reset = 1'b1;
        #1;
        n_tests++;
        if (bus.ca_ps_act !== 1'b0 || bus.fault_latched !== 1'b0 ||
            bus.fault_code !== 3'd0) begin
            n_fail++;
            $display("FAIL arst_run act=%b latch=%b code=%0d",
                     bus.ca_ps_act, bus.fault_latched, bus.fault_code);
        end
        tick();
        reset = 1'b0;
        idle_inputs();
        tick();
    endtask

    initial begin
        test_reset();
        test_nominal();
        test_stop_early();
        test_timeout();
        test_codes();
        test_priority();
`ifdef CA_AUTO_RETRY_EN
        test_retry();
`else
        test_no_retry();
`endif
        test_async_reset();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/ca_ps_sequencer.md
CA_PS_SEQUENCER -- requirements
Module: ca_ps_sequencer

Interface
REQ-001 Parameters, one per line (name, default, meaning):
  OK_TIMEOUT, 4352, max cycles in WAIT_OK before timeout fault (covers 4 s + 60 s interlock chain)
  BACKOFF_CYCLES, 512, cycles held in BACKOFF before re-arm
  MAX_RETRY, 3, faults allowed before LOCKOUT (retry build only)
REQ-002 Ports, one per line (name, direction, width, meaning):
  clk  in  1  single clock; all state on rising edge
  reset  in  1  asynchronous, active-high
  start_req  in  1  operator request to energise CA supply
  stop_req  in  1  operator request to de-energise
  fault_ack  in  1  operator fault acknowledge
  perm_n  in  1  CA-on permission from interlock card, low = permitted
  not_ca_ok  in  1  interlock card CA-OK, low = OK
  i_high_n  in  1  overcurrent flag, low = fault
  u_low_n  in  1  undervoltage flag, low = fault
  ca_ps_act  out  1  CA supply activate command to interlock card
  state  out  3  current state code
  fault_latched  out  1  a fault has occurred and is not yet acknowledged
  fault_code  out  3  first-cause code of latched fault
  retry_cnt  out  2  faults since last clean stop/ack, saturating at 3
REQ-003 All outputs SHALL be registered; no combinational input-to-output paths.

Function
REQ-004 States/codes: IDLE=0, ARM=1, WAIT_OK=2, RUN=3, FAULT=4, BACKOFF=5, LOCKOUT=6; code 7 unreachable, and it SHALL go to LOCKOUT.
REQ-005 ca_ps_act SHALL be 1 exactly while state is ARM, WAIT_OK or RUN; it changes on the same edge as state.
REQ-006 IDLE: start_req=1 and perm_n=0 -> ARM; start_req with perm_n=1 is ignored.
REQ-007 ARM: lasts one cycle and clears the wait timer -> WAIT_OK.
REQ-008 WAIT_OK: timer increments each cycle; not_ca_ok=0 -> RUN; timer = OK_TIMEOUT-1 without OK -> FAULT, code 5 (TIMEOUT).
REQ-009 RUN: i_high_n=0 -> FAULT code 2 (OC); u_low_n=0 -> code 3 (UV); not_ca_ok=1 -> code 4 (OK_LOST).
REQ-010 In ARM, WAIT_OK or RUN: perm_n=1 -> FAULT code 1 (PERM).
REQ-011 Simultaneous fault priority: PERM > OC > UV > OK_LOST > TIMEOUT; any fault beats stop_req in the same cycle.
REQ-012 stop_req=1 in ARM, WAIT_OK, RUN or BACKOFF with no fault that cycle -> IDLE; retry_cnt cleared to 0.
REQ-013 FAULT: lasts one cycle; sets fault_latched=1; increments retry_cnt, saturating at 3.
REQ-014 fault_code SHALL capture only the first cause while fault_latched=1; later faults leave it unchanged.
REQ-015 LOCKOUT: holds until fault_ack=1 and perm_n=0 -> IDLE, clearing fault_latched, fault_code and retry_cnt.
REQ-016 fault_ack in any state other than LOCKOUT or BACKOFF SHALL have no effect.

Reset
REQ-017 reset=1 asynchronously forces: state=IDLE, ca_ps_act=0, fault_latched=0, fault_code=0, retry_cnt=0, timers=0.
REQ-018 reset asserted mid-RUN SHALL drop ca_ps_act with no FAULT recorded.

Configuration
REQ-019 Macro CA_AUTO_RETRY_EN. Defined: FAULT -> BACKOFF if the post-increment retry_cnt <= MAX_RETRY, else LOCKOUT. In BACKOFF, fault_ack -> IDLE with the same clears as REQ-015.
REQ-020 CA_AUTO_RETRY_EN defined: BACKOFF counts BACKOFF_CYCLES, then -> ARM if perm_n=0, else it waits there. fault_latched stays 1 through the re-arm.
REQ-021 CA_AUTO_RETRY_EN undefined: FAULT always -> LOCKOUT; BACKOFF unreachable; retry_cnt still counts.

Verification (OK_TIMEOUT=16, BACKOFF_CYCLES=8, MAX_RETRY=2)
REQ-022 Nominal: perm_n=0, start_req pulse, not_ca_ok low 5 cycles later -> state 0->1->2->3, ca_ps_act=1 from the ARM edge; stop_req -> IDLE, ca_ps_act=0 next edge.
REQ-023 Timeout: start_req, not_ca_ok held 1 -> FAULT after exactly 16 WAIT_OK cycles, fault_code=5, ca_ps_act=0.
REQ-024 Priority: in RUN, assert perm_n=1, i_high_n=0 and stop_req together -> FAULT, fault_code=1; then i_high_n=0 in a re-run leaves fault_code=1.
REQ-025 Retry (macro defined): three consecutive OC faults -> BACKOFF, BACKOFF, then LOCKOUT with retry_cnt=3; fault_ack with perm_n=0 -> IDLE, retry_cnt=0.
REQ-026 No retry (macro undefined): single UV fault in RUN -> FAULT -> LOCKOUT; fault_ack with perm_n=1 stays in LOCKOUT.
REQ-027 Async reset mid-WAIT_OK, between clock edges -> ca_ps_act=0 and state=0 immediately; fault_latched=0.
